serial_adder: RTL and testbench

- Parametrised multi-cycle adder: computes a + b + cin using one DIGIT-bit full-adder slice plus a registered carry, LSB digit first.
- Generalises the team's single-bit full adder to WIDTH bits with a start/done handshake.
- Used as an area-lean arithmetic unit in datapaths where latency is acceptable.

---
 rtl/serial_adder.sv | 166 ++++++++++++++++
 tb/tb_serial_adder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle unsigned adder computing a + b + cin with one DIGIT-bit
// adder slice and a registered carry, least-significant digit first.
//
// Parameters:
//   WIDTH  operand/sum width in bits (>= 1)
//   DIGIT  bits processed per clock; must divide WIDTH
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous reset, active-high
//   start  request, accepted only while ready=1
//   a, b   operands, sampled on the accepted-start edge
//   cin    carry-in, sampled on the accepted-start edge
//   ready  idle, able to accept start
//   busy   computation in progress
//   done   one-cycle pulse; sum/cout valid from this cycle
//   sum    result, held until the next done
//   cout   carry out of the MSB, held with sum
//   ovf    (only with SERIAL_ADDER_OVF_EN defined) two's-complement signed overflow,
//          held with sum
//
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf output.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned STEPS = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] r_shift;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
    logic             msb_cin;
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_d     = r_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        dsum = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]} + (DIGIT + 1)'(c_q);

        // New digit enters the top of the result register; after STEPS shifts the
        // first digit computed has reached bit 0.
        r_shift = r_q >> DIGIT;
        r_shift[WIDTH-1 -: DIGIT] = dsum[DIGIT-1:0];

`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
        // Carry into the MSB recovered from the MSB sum bit of the final digit.
        msb_cin = dsum[DIGIT-1] ^ a_sh_q[DIGIT-1] ^ b_sh_q[DIGIT-1];
`endif

        case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy   = 1'b1;
                a_sh_d = a_sh_q >> DIGIT;
                b_sh_d = b_sh_q >> DIGIT;
                r_d    = r_shift;
                c_d    = dsum[DIGIT];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Final digit: publish the completed result on the DONE-entry edge.
                    cnt_d   = '0;
                    sum_d   = r_shift;
                    cout_d  = dsum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = msb_cin ^ dsum[DIGIT];
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_q     <= r_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: one DIGIT=1 and one DIGIT=4 instance (WIDTH=8) sharing
// clock, reset and operand inputs; expected results queue per instance.
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start4 = 1'b0;
    logic [7:0] a_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic       cin_in = 1'b0;

    logic       ready1, busy1, done1, cout1, ovf1;
    logic       ready4, busy4, done4, cout4, ovf4;
    logic [7:0] sum1, sum4;

    int checks = 0;
    int errors = 0;
    int ndone1 = 0;
    int ndone4 = 0;
    logic [7:0] prev1 = 8'h00;
    logic [7:0] prev4 = 8'h00;
    exp_t q1[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a_in),
        .b     (b_in),
        .cin   (cin_in),
        .ready (ready1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a_in),
        .b     (b_in),
        .cin   (cin_in),
        .ready (ready4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf4)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf1 = 1'b0;
    assign ovf4 = 1'b0;
`endif

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic ci);
        exp_t e;
        logic [8:0] t;
        t   = {1'b0, x} + {1'b0, y} + 9'(ci);
        e.s = t[7:0];
        e.c = t[8];
        e.o = (x[7] == y[7]) && (t[7] != x[7]);
        return e;
    endfunction

    // Scoreboards: every done pulse pops and checks one expected result.
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            exp_t e;
            ndone1++;
            checks++;
            assert (q1.size() > 0) else begin
                errors++;
                $error("FAIL sb1_unexpected_done: pending=%0d required>0", q1.size());
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                checks++;
                assert (sum1 === e.s) else begin
                    errors++;
                    $error("FAIL sb1_sum: got %h want %h", sum1, e.s);
                end
                checks++;
                assert (cout1 === e.c) else begin
                    errors++;
                    $error("FAIL sb1_cout: got %b want %b", cout1, e.c);
                end
`ifdef SERIAL_ADDER_OVF_EN
                checks++;
                assert (ovf1 === e.o) else begin
                    errors++;
                    $error("FAIL sb1_ovf: got %b want %b", ovf1, e.o);
                end
`endif
            end
        end
        if (done4 === 1'b1) begin
            exp_t e;
            ndone4++;
            checks++;
            assert (q4.size() > 0) else begin
                errors++;
                $error("FAIL sb4_unexpected_done: pending=%0d required>0", q4.size());
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                checks++;
                assert (sum4 === e.s) else begin
                    errors++;
                    $error("FAIL sb4_sum: got %h want %h", sum4, e.s);
                end
                checks++;
                assert (cout4 === e.c) else begin
                    errors++;
                    $error("FAIL sb4_cout: got %b want %b", cout4, e.c);
                end
`ifdef SERIAL_ADDER_OVF_EN
                checks++;
                assert (ovf4 === e.o) else begin
                    errors++;
                    $error("FAIL sb4_ovf: got %b want %b", ovf4, e.o);
                end
`endif
            end
        end
    end

    // One transaction on the selected instance (1 or 4) with latency, hold and
    // handshake checks along the way.
    task automatic do_op(input int sel, input logic [7:0] x, input logic [7:0] y,
                         input logic ci);
        exp_t e;
        int   k;
        int   steps;
        logic dn, bz, rd;
        logic [7:0] cur, prev;
        e     = model(x, y, ci);
        steps = (sel == 1) ? 8 : 2;
        prev  = (sel == 1) ? prev1 : prev4;
        @(negedge clk);
        a_in   = x;
        b_in   = y;
        cin_in = ci;
        if (sel == 1) start1 = 1'b1;
        else          start4 = 1'b1;
        @(posedge clk);
        if (sel == 1) q1.push_back(e);
        else          q4.push_back(e);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        a_in   = ~x;
        b_in   = 8'($urandom);
        cin_in = ~ci;
        k = 0;
        dn = 1'b0;
        while (!dn && k < 40) begin
            @(negedge clk);
            k++;
            dn  = (sel == 1) ? done1 : done4;
            bz  = (sel == 1) ? busy1 : busy4;
            rd  = (sel == 1) ? ready1 : ready4;
            cur = (sel == 1) ? sum1 : sum4;
            if (!dn) begin
                checks++;
                assert (cur === prev) else begin
                    errors++;
                    $error("FAIL sum_hold_run: got %h want %h", cur, prev);
                end
                checks++;
                assert (bz === 1'b1 && rd === 1'b0) else begin
                    errors++;
                    $error("FAIL run_flags: busy=%b ready=%b want busy=1 ready=0", bz, rd);
                end
            end else begin
                checks++;
                assert (bz === 1'b0 && rd === 1'b0) else begin
                    errors++;
                    $error("FAIL done_flags: busy=%b ready=%b want 0 0", bz, rd);
                end
            end
        end
        checks++;
        assert (k === steps + 1) else begin
            errors++;
            $error("FAIL latency: done in cycle %0d after accept, want %0d", k, steps + 1);
        end
        if (sel == 1) prev1 = e.s;
        else          prev4 = e.s;
        @(negedge clk);
        rd = (sel == 1) ? ready1 : ready4;
        dn = (sel == 1) ? done1 : done4;
        checks++;
        assert (rd === 1'b1 && dn === 1'b0) else begin
            errors++;
            $error("FAIL ready_after_done: ready=%b done=%b want 1 0", rd, dn);
        end
    endtask

    initial begin
        int d0;
        // Reset
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        assert (ready1 === 1'b1 && busy1 === 1'b0 && done1 === 1'b0) else begin
            errors++;
            $error("FAIL reset_flags1: r/b/d=%b%b%b want 100", ready1, busy1, done1);
        end
        checks++;
        assert (sum1 === 8'h00 && cout1 === 1'b0 && ovf1 === 1'b0) else begin
            errors++;
            $error("FAIL reset_out1: sum=%h cout=%b ovf=%b want 00 0 0", sum1, cout1, ovf1);
        end
        checks++;
        assert (ready4 === 1'b1 && busy4 === 1'b0 && sum4 === 8'h00 && cout4 === 1'b0) else begin
            errors++;
            $error("FAIL reset4: ready=%b busy=%b sum=%h cout=%b want 1 0 00 0",
                   ready4, busy4, sum4, cout4);
        end

        // Directed adds, bit-serial and 4-bit digit
        do_op(1, 8'h5A, 8'h33, 1'b0);
        do_op(1, 8'hFF, 8'h01, 1'b0);
        do_op(1, 8'hFF, 8'hFF, 1'b1);
        do_op(4, 8'h5A, 8'h33, 1'b0);
        do_op(4, 8'hFF, 8'hFF, 1'b1);
        do_op(4, 8'h80, 8'h80, 1'b0);
        // Signed-overflow corners
        do_op(1, 8'h7F, 8'h01, 1'b0);
        do_op(1, 8'h80, 8'h80, 1'b0);
        do_op(1, 8'h10, 8'h20, 1'b0);

        // start held high, operands changing every cycle
        d0 = ndone1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            a_in   = 8'($urandom);
            b_in   = 8'($urandom);
            cin_in = 1'($urandom);
            start1 = 1'b1;
            checks++;
            assert (ready1 === ((i % 10) == 0)) else begin
                errors++;
                $error("FAIL b2b_ready: cycle %0d ready=%b want %b", i, ready1, (i % 10) == 0);
            end
            if ((i % 10) == 0) q1.push_back(model(a_in, b_in, cin_in));
        end
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        assert (ndone1 - d0 === 3) else begin
            errors++;
            $error("FAIL b2b_done_count: got %0d want 3", ndone1 - d0);
        end
        prev1 = sum1;

        // Reset during RUN cycle 3 aborts the operation
        @(negedge clk);
        a_in   = 8'hC3;
        b_in   = 8'h5A;
        cin_in = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        d0 = ndone1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        assert (ready1 === 1'b1 && busy1 === 1'b0 && done1 === 1'b0) else begin
            errors++;
            $error("FAIL abort_flags: r/b/d=%b%b%b want 100", ready1, busy1, done1);
        end
        checks++;
        assert (sum1 === 8'h00 && cout1 === 1'b0 && ovf1 === 1'b0) else begin
            errors++;
            $error("FAIL abort_out: sum=%h cout=%b ovf=%b want 00 0 0", sum1, cout1, ovf1);
        end
        repeat (12) @(negedge clk);
        checks++;
        assert (ndone1 === d0) else begin
            errors++;
            $error("FAIL abort_no_done: got %0d done pulses want 0", ndone1 - d0);
        end
        prev1 = 8'h00;
        prev4 = 8'h00;
        do_op(1, 8'hC3, 8'h3C, 1'b1);
        do_op(4, 8'h0F, 8'hF1, 1'b0);

        repeat (4) @(negedge clk);
        checks++;
        assert (q1.size() === 0 && q4.size() === 0) else begin
            errors++;
            $error("FAIL sb_leftover: pending %0d/%0d want 0/0", q1.size(), q4.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
